microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Reader/consumer side of the 17-bit microcode control store in the multicycle RV32I controller.
- Holds the micro-program counter (uPC), drives it as the control-store address, and takes back the combinational 17-bit microword.
- Splits the microword into datapath control strobes and computes the next uPC from the microword's 3-bit sequencing field, the instruction opcode and a memory-ready handshake.
- Detects illegal opcodes and sequencing codes, and counts retired instructions.

Parameters:
- UPC_W, 4, width of uPC / control-store address.
- UWORD_W, 17, microword width.
- HALT_UPC, 4'hF, uPC value parked in when halted.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- uaddr  out  UPC_W  control-store address (= uPC register).
- uword  in  UWORD_W  microword returned combinationally for uaddr.
- opcode  in  7  instr[6:0] from instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes access this cycle.
- pc_write  out  1  PC load enable.
- reg_write  out  1  register file write enable.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register load enable.
- adr_src  out  1  memory address select.
- result_src  out  2  result mux select.
- alu_src_a  out  2  ALU A select.
- alu_src_b  out  2  ALU B select.
- alu_op  out  2  ALU decoder op class.
- halted  out  1  sticky illegal/halt flag.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: uPC=0, halted=0, instret=0.
- Microword fields, MSB first: [16] branch, [15] pc_update, [14] reg_write, [13] mem_write, [12] ir_write, [11] adr_src, [10:9] result_src, [8:7] alu_src_a, [6:5] alu_src_b, [4:3] alu_op, [2:0] seq.
- Outputs are combinational from uword. pc_write = pc_update | (branch & zero).
- Memory state: any word with ir_write|mem_write|adr_src set.
  - In a memory state with mem_ready=0: uPC holds, and pc_write, reg_write, mem_write, ir_write are forced to 0. Mux selects still pass through.
  - With mem_ready=1: normal advance.
- Next-uPC by seq, registered on clk:
  - 000 → uPC+1.
  - 001 (decode dispatch) by opcode: 0000011/0100011→2, 0110011→6, 0010011→8, 1101111→9, 1100011→10, anything else→halt.
  - 010 (mem dispatch): 0000011→3, 0100011→5, anything else→halt.
  - 011 → 0 (instruction retires).
  - 100 → 7.
  - 101–111 → halt.
- Halt: uPC←HALT_UPC and halted←1. While halted:
  - all enable outputs = 0 and all selects = 0, regardless of uword;
  - uPC stays HALT_UPC.
  - Only rst_n clears halt.
- uPC+1 from 4'hE must not be reached by a legal program. If uPC+1 would yield HALT_UPC, treat it as halt.
- instret increments by 1 on each clock edge where seq=011 is taken (not stalled, not halted). It wraps modulo 2^CNT_W.
- Latency: one clock per microstep, plus one extra cycle per stalled memory cycle. Single-cycle state register, no pipelining.
- Reset asserted mid-instruction immediately forces uaddr=0 and clears halted/instret. The first rising edge after release advances from uPC 0.

Test Plan:
- lw (opcode 0000011), mem_ready=1 always → uaddr sequence 0,1,2,3,4,0; reg_write=1 only in uPC 4, result_src=01; instret 0→1.
- sw (0100011) with mem_ready low 2 cycles in uPC 5 → uaddr 0,1,2,5,5,5,0; mem_write=0 while stalled and 1 in the ready cycle.
- beq (1100011), zero=1 then repeat with zero=0 → uaddr 0,1,10,0; pc_write=1 in uPC 10 only when zero=1; alu_op=01.
- R-type (0110011) then jal (1101111) back-to-back → 0,1,6,7,0,1,9,7,0; instret=2; pc_write=1 in uPC 9.
- Illegal opcode 1111111 at decode → next cycle uaddr=4'hF, halted=1, all enables 0 for 10 further cycles; instret unchanged.
- rst_n pulsed low asynchronously while uPC=3 → uaddr=0 immediately, before the next edge; halted=0, instret=0; normal fetch resumes after release.

Source files
------------

// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : microcode_sequencer
// Brief    : Microprogram sequencer for the multicycle RV32I controller.
//            Owns the uPC, decodes the microword into strobes, and counts
//            retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module microcode_sequencer #(
    parameter int                 UPC_W    = 4,
    parameter int                 UWORD_W  = 17,
    parameter logic [UPC_W-1:0]   HALT_UPC = 4'hF,
    parameter int                 CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [UPC_W-1:0]   uaddr,
    input  logic [UWORD_W-1:0] uword,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               reg_write,
    output logic               mem_write,
    output logic               ir_write,
    output logic               adr_src,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               halted,
    output logic [CNT_W-1:0]   instret
);

    localparam logic [2:0] c_SEQ_NEXT   = 3'b000;
    localparam logic [2:0] c_SEQ_DECODE = 3'b001;
    localparam logic [2:0] c_SEQ_MEM    = 3'b010;
    localparam logic [2:0] c_SEQ_RETIRE = 3'b011;
    localparam logic [2:0] c_SEQ_WB     = 3'b100;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [UPC_W-1:0] c_UPC_FETCH    = UPC_W'(0);
    localparam logic [UPC_W-1:0] c_UPC_MEMADR   = UPC_W'(2);
    localparam logic [UPC_W-1:0] c_UPC_MEMREAD  = UPC_W'(3);
    localparam logic [UPC_W-1:0] c_UPC_MEMWRITE = UPC_W'(5);
    localparam logic [UPC_W-1:0] c_UPC_EXECR    = UPC_W'(6);
    localparam logic [UPC_W-1:0] c_UPC_ALUWB    = UPC_W'(7);
    localparam logic [UPC_W-1:0] c_UPC_EXECI    = UPC_W'(8);
    localparam logic [UPC_W-1:0] c_UPC_JAL      = UPC_W'(9);
    localparam logic [UPC_W-1:0] c_UPC_BEQ      = UPC_W'(10);

    logic [UPC_W-1:0] r_upc;
    logic             r_halted;
    logic [CNT_W-1:0] r_instret;

    logic [UPC_W-1:0] w_upc_inc;
    logic [UPC_W-1:0] w_upc_next;
    logic             w_go_halt;
    logic             w_retire;
    logic             w_mem_state;
    logic             w_stall;
    logic [2:0]       w_seq;

    assign w_seq       = uword[2:0];
    assign w_mem_state = uword[13] | uword[12] | uword[11];
    assign w_stall     = w_mem_state & ~mem_ready;
    assign w_upc_inc   = r_upc + 1'b1;

    always_comb begin
        w_upc_next = r_upc;
        w_go_halt  = 1'b0;
        w_retire   = 1'b0;
        case (w_seq)
            // Falling through into the park address is never legal microcode.
            c_SEQ_NEXT: begin
                if (w_upc_inc == HALT_UPC) w_go_halt  = 1'b1;
                else                       w_upc_next = w_upc_inc;
            end
            c_SEQ_DECODE: begin
                case (opcode)
                    c_OP_LOAD, c_OP_STORE: w_upc_next = c_UPC_MEMADR;
                    c_OP_RTYPE:            w_upc_next = c_UPC_EXECR;
                    c_OP_ITYPE:            w_upc_next = c_UPC_EXECI;
                    c_OP_JAL:              w_upc_next = c_UPC_JAL;
                    c_OP_BRANCH:           w_upc_next = c_UPC_BEQ;
                    default:               w_go_halt  = 1'b1;
                endcase
            end
            c_SEQ_MEM: begin
                case (opcode)
                    c_OP_LOAD:  w_upc_next = c_UPC_MEMREAD;
                    c_OP_STORE: w_upc_next = c_UPC_MEMWRITE;
                    default:    w_go_halt  = 1'b1;
                endcase
            end
            c_SEQ_RETIRE: begin
                w_upc_next = c_UPC_FETCH;
                w_retire   = 1'b1;
            end
            c_SEQ_WB: w_upc_next = c_UPC_ALUWB;
            default:  w_go_halt  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upc     <= c_UPC_FETCH;
            r_halted  <= 1'b0;
            r_instret <= '0;
        end else if (!r_halted && !w_stall) begin
            if (w_go_halt) begin
                r_upc    <= HALT_UPC;
                r_halted <= 1'b1;
            end else begin
                r_upc <= w_upc_next;
            end
            if (w_retire) r_instret <= r_instret + 1'b1;
        end
    end

    // Selects pass through during a stall; only the state-changing strobes are held off.
    always_comb begin
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        if (!r_halted) begin
            adr_src    = uword[11];
            result_src = uword[10:9];
            alu_src_a  = uword[8:7];
            alu_src_b  = uword[6:5];
            alu_op     = uword[4:3];
            if (!w_stall) begin
                pc_write  = uword[15] | (uword[16] & zero);
                reg_write = uword[14];
                mem_write = uword[13];
                ir_write  = uword[12];
            end
        end
    end

    assign uaddr   = r_upc;
    assign halted  = r_halted;
    assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_microcode_sequencer
// Brief    : Directed self-checking bench driving a small RV32I control store.
// Revision : 1.0 - initial release
// ============================================================================
module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  uaddr;
    logic [16:0] uword;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, reg_write, mem_write, ir_write, adr_src, halted;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
    logic [31:0] instret;

    logic [16:0] rom [16];
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ILL  = 7'b1111111;

    always #5 clk = ~clk;

    always_comb uword = rom[uaddr];

    microcode_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uaddr      (uaddr),
        .uword      (uword),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .adr_src    (adr_src),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .halted     (halted),
        .instret    (instret)
    );

    function automatic logic [16:0] mw(input logic br, input logic pcu, input logic rw,
                                       input logic mwr, input logic irw, input logic adr,
                                       input logic [1:0] res, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op,
                                       input logic [2:0] sq);
        return {br, pcu, rw, mwr, irw, adr, res, a, b, op, sq};
    endfunction

    task automatic load_rom();
        for (int i = 0; i < 16; i++) rom[i] = 17'h00007;
        rom[0]  = mw(0,1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000); // fetch
        rom[1]  = mw(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b001); // decode
        rom[2]  = mw(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010); // memadr
        rom[3]  = mw(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000); // memread
        rom[4]  = mw(0,0,1,0,0,0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011); // memwb
        rom[5]  = mw(0,0,0,1,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b011); // memwrite
        rom[6]  = mw(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b100); // execR
        rom[7]  = mw(0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b011); // aluwb
        rom[8]  = mw(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b100); // execI
        rom[9]  = mw(0,1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b100); // jal
        rom[10] = mw(1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b011); // beq
        rom[15] = 17'h1FFFF;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = OP_LW; zero = 1'b0; mem_ready = 1'b1;
        #1;
        n_checks++;
        if (uaddr !== 4'd0 || halted !== 1'b0 || instret !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: uaddr=%0d halted=%b instret=%0d, want 0 0 0", uaddr, halted, instret);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_stall();
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (ir_write !== 1'b0 || pc_write !== 1'b0 || result_src !== 2'b10 || alu_src_b !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_stall_strobes: ir=%b pc=%b res=%b b=%b, want 0 0 10 10", ir_write, pc_write, result_src, alu_src_b);
        end
        step();
        n_checks++;
        if (uaddr !== 4'd0) begin
            n_fail++;
            $display("FAIL fetch_stall_hold: uaddr=%0d, want 0", uaddr);
        end
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_ready_strobes: ir=%b pc=%b, want 1 1", ir_write, pc_write);
        end
    endtask

    task automatic test_lw(input logic [31:0] exp_ret);
        logic [3:0] exp [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (uaddr !== exp[i] || reg_write !== (i == 4)) begin
                n_fail++;
                $display("FAIL lw_seq[%0d]: uaddr=%0d reg_write=%b, want %0d %b", i, uaddr, reg_write, exp[i], (i == 4));
            end
            if (i == 4) begin
                n_checks++;
                if (result_src !== 2'b01) begin
                    n_fail++;
                    $display("FAIL lw_result_src: got %b, want 01", result_src);
                end
            end
            if (i < 5) step();
        end
        n_checks++;
        if (instret !== exp_ret) begin
            n_fail++;
            $display("FAIL lw_instret: got %0d, want %0d", instret, exp_ret);
        end
    endtask

    task automatic test_sw_stall();
        logic [3:0] exp [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd0};
        opcode = OP_SW;
        for (int i = 0; i < 7; i++) begin
            mem_ready = !(i == 3 || i == 4);
            #1;
            n_checks++;
            if (uaddr !== exp[i] || mem_write !== (i == 5)) begin
                n_fail++;
                $display("FAIL sw_seq[%0d]: uaddr=%0d mem_write=%b, want %0d %b", i, uaddr, mem_write, exp[i], (i == 5));
            end
            if (i < 6) step();
        end
        mem_ready = 1'b1;
        n_checks++;
        if (instret !== 32'd2) begin
            n_fail++;
            $display("FAIL sw_instret: got %0d, want 2", instret);
        end
    endtask

    task automatic test_beq();
        logic [3:0] exp [4] = '{4'd0, 4'd1, 4'd10, 4'd0};
        opcode = OP_BEQ;
        for (int pass = 0; pass < 2; pass++) begin
            zero = (pass == 0);
            for (int i = 0; i < 4; i++) begin
                #1;
                n_checks++;
                if (uaddr !== exp[i]) begin
                    n_fail++;
                    $display("FAIL beq_seq[%0d/%0d]: uaddr=%0d, want %0d", pass, i, uaddr, exp[i]);
                end
                if (i == 2) begin
                    n_checks++;
                    if (pc_write !== (pass == 0) || alu_op !== 2'b01) begin
                        n_fail++;
                        $display("FAIL beq_pcw[%0d]: pc_write=%b alu_op=%b, want %b 01", pass, pc_write, alu_op, (pass == 0));
                    end
                end
                if (i < 3) step();
            end
        end
        zero = 1'b0;
        n_checks++;
        if (instret !== 32'd4) begin
            n_fail++;
            $display("FAIL beq_instret: got %0d, want 4", instret);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp [9] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd9, 4'd7, 4'd0};
        for (int i = 0; i < 9; i++) begin
            opcode = (i < 4) ? OP_R : OP_JAL;
            #1;
            n_checks++;
            if (uaddr !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_seq[%0d]: uaddr=%0d, want %0d", i, uaddr, exp[i]);
            end
            if (i == 2 || i == 6) begin
                n_checks++;
                if (pc_write !== (i == 6)) begin
                    n_fail++;
                    $display("FAIL b2b_pcw[%0d]: pc_write=%b, want %b", i, pc_write, (i == 6));
                end
            end
            if (i < 8) step();
        end
        n_checks++;
        if (instret !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_instret: got %0d, want 6", instret);
        end
    endtask

    task automatic test_illegal();
        opcode = OP_ILL;
        step();
        #1;
        n_checks++;
        if (uaddr !== 4'd1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_decode: uaddr=%0d halted=%b, want 1 0", uaddr, halted);
        end
        for (int i = 0; i < 11; i++) begin
            step();
            mem_ready = i[0];
            zero      = 1'b1;
            #1;
            n_checks++;
            if (uaddr !== 4'hF || halted !== 1'b1 || instret !== 32'd6 ||
                {pc_write, reg_write, mem_write, ir_write, adr_src,
                 result_src, alu_src_a, alu_src_b, alu_op} !== 13'd0) begin
                n_fail++;
                $display("FAIL ill_halt[%0d]: uaddr=%0d halted=%b instret=%0d en=%b%b%b%b%b sel=%b%b%b%b",
                         i, uaddr, halted, instret, pc_write, reg_write, mem_write, ir_write,
                         adr_src, result_src, alu_src_a, alu_src_b, alu_op);
            end
        end
        mem_ready = 1'b1; zero = 1'b0; opcode = OP_LW;
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (uaddr !== 4'd0 || halted !== 1'b0 || instret !== 32'd0) begin
            n_fail++;
            $display("FAIL halt_clear: uaddr=%0d halted=%b instret=%0d, want 0 0 0", uaddr, halted, instret);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_lw(32'd1);
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (uaddr !== 4'd3) begin
            n_fail++;
            $display("FAIL areset_pre: uaddr=%0d, want 3", uaddr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (uaddr !== 4'd0 || halted !== 1'b0 || instret !== 32'd0) begin
            n_fail++;
            $display("FAIL areset_mid: uaddr=%0d halted=%b instret=%0d, want 0 0 0", uaddr, halted, instret);
        end
        #1 rst_n = 1'b1;
        step();
        n_checks++;
        if (uaddr !== 4'd1) begin
            n_fail++;
            $display("FAIL areset_resume: uaddr=%0d, want 1", uaddr);
        end
    endtask

    initial begin
        load_rom();
        test_reset();
        test_fetch_stall();
        step();
        step();
        step();
        step();
        step();
        test_reset();
        test_lw(32'd1);
        test_sw_stall();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
